// File: rtl/priority_request_arbiter.sv
// Priority request arbiter: sticky pending capture, one-hot grants with valid/ack and ack timeout.
// Optional rotating priority when PRIO_ARB_ROUND_ROBIN_EN is defined; fixed highest-index otherwise.
module priority_request_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 15,
    localparam int IDW    = $clog2(N)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_req,
    output logic [N-1:0]   o_pending,
    output logic           o_any_pending,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_gnt_id,
    output logic           o_gnt_valid,
    input  logic           i_gnt_ack,
    output logic           o_timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_RETIRE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_pending;
    logic [N-1:0]   w_pending_nxt;
    logic [N-1:0]   w_clr_mask;
    logic           r_any_pending;
    logic [N-1:0]   r_gnt;
    logic [N-1:0]   w_gnt_nxt;
    logic [IDW-1:0] r_gnt_id;
    logic [IDW-1:0] w_gnt_id_nxt;
    logic [IDW-1:0] w_sel_idx;
    logic           r_gnt_valid;
    logic           w_gnt_valid_nxt;
    logic           r_timeout_err;
    logic           w_timeout_err_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] r_ptr;

    // First set bit searching downward (modulo N) from the start index.
    function automatic logic [IDW-1:0] f_rotate_sel(input logic [N-1:0] p, input logic [IDW-1:0] start);
        logic [IDW-1:0] idx;
        logic [IDW-1:0] j;
        logic           found;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = IDW'((int'(start) + N - k) % N);
            if (!found && p[j]) begin
                idx   = j;
                found = 1'b1;
            end else begin
                idx   = idx;
            end
        end
        return idx;
    endfunction

    // Rotation pointer: the retired channel becomes lowest priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= IDW'(N - 1);
        end else if (|w_clr_mask) begin
            r_ptr <= (r_gnt_id == '0) ? IDW'(N - 1) : (r_gnt_id - IDW'(1));
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign w_sel_idx = f_rotate_sel(r_pending, r_ptr);
`else
    function automatic logic [IDW-1:0] f_highest_sel(input logic [N-1:0] p);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = p[i] ? IDW'(i) : idx;
        end
        return idx;
    endfunction

    assign w_sel_idx = f_highest_sel(r_pending);
`endif

    // Set wins over clear when a request lands on the channel being retired.
    assign w_pending_nxt = (r_pending & ~w_clr_mask) | i_req;

    // Next-state and next-output logic for the grant FSM.
    always_comb begin
        w_state_nxt       = r_state;
        w_clr_mask        = '0;
        w_cnt_nxt         = r_cnt;
        w_gnt_nxt         = r_gnt;
        w_gnt_id_nxt      = r_gnt_id;
        w_gnt_valid_nxt   = r_gnt_valid;
        w_timeout_err_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_gnt_nxt       = N'(1) << w_sel_idx;
                    w_gnt_id_nxt    = w_sel_idx;
                    w_gnt_valid_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = ST_GRANT;
                end else begin
                    w_state_nxt     = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (i_gnt_ack || (r_cnt == CW'(TIMEOUT - 1))) begin
                    w_clr_mask        = r_gnt;
                    w_timeout_err_nxt = ~i_gnt_ack;
                    w_gnt_nxt         = '0;
                    w_gnt_id_nxt      = '0;
                    w_gnt_valid_nxt   = 1'b0;
                    w_state_nxt       = ST_RETIRE;
                end else begin
                    w_cnt_nxt         = r_cnt + CW'(1);
                end
            end
            ST_RETIRE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_gnt_nxt       = '0;
                w_gnt_id_nxt    = '0;
                w_gnt_valid_nxt = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    // State, pending capture and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_pending     <= '0;
            r_any_pending <= 1'b0;
            r_gnt         <= '0;
            r_gnt_id      <= '0;
            r_gnt_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pending     <= w_pending_nxt;
            r_any_pending <= |w_pending_nxt;
            r_gnt         <= w_gnt_nxt;
            r_gnt_id      <= w_gnt_id_nxt;
            r_gnt_valid   <= w_gnt_valid_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign o_pending     = r_pending;
    assign o_any_pending = r_any_pending;
    assign o_gnt         = r_gnt;
    assign o_gnt_id      = r_gnt_id;
    assign o_gnt_valid   = r_gnt_valid;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_priority_request_arbiter.sv
// Bench for priority_request_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant owner, grant age, post-retire gap).
module tb_priority_request_arbiter;

    localparam int N   = 4;
    localparam int T   = 4;
    localparam int IDW = $clog2(N);

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   pending;
    logic           any_pending;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           gnt_ack;
    logic           timeout_err;

    priority_request_arbiter #(.N(N), .TIMEOUT(T)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .o_pending     (pending),
        .o_any_pending (any_pending),
        .o_gnt         (gnt),
        .o_gnt_id      (gnt_id),
        .o_gnt_valid   (gnt_valid),
        .i_gnt_ack     (gnt_ack),
        .o_timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: which channel holds the grant (-1 none), how long it has waited, retire gap.
    logic [N-1:0] m_pend;
    int           m_gid;
    int           m_age;
    int           m_gap;
    int           m_ptr;
    logic         m_terr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] p, input int start);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start - k + N) % N;
            if (p[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = '0;
        m_gid  = -1;
        m_age  = 0;
        m_gap  = 0;
        m_ptr  = N - 1;
        m_terr = 1'b0;
    endtask

    task automatic model_update(input logic [N-1:0] r, input logic a);
        int           clr;
        logic [N-1:0] old;
        clr    = -1;
        old    = m_pend;
        m_terr = 1'b0;
        if (m_gid >= 0) begin
            if (a) clr = m_gid;
            else if (m_age == T - 1) begin
                clr    = m_gid;
                m_terr = 1'b1;
            end else m_age++;
            if (clr >= 0) begin
                m_gid = -1;
                m_gap = 1;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
                m_ptr = (clr + N - 1) % N;
`endif
            end
        end else if (m_gap > 0) begin
            m_gap = 0;
        end else if (old != '0) begin
            m_gid = pick(old, m_ptr);
            m_age = 0;
        end
        if (clr >= 0) m_pend[clr] = 1'b0;
        m_pend = m_pend | r;
    endtask

    task automatic compare_all();
        logic [N-1:0] e_gnt;
        e_gnt = (m_gid >= 0) ? (N'(1) << m_gid) : '0;
        check_val("pending", 32'(pending), 32'(m_pend));
        check_val("any_pending", 32'(any_pending), 32'(|m_pend));
        check_val("gnt", 32'(gnt), 32'(e_gnt));
        check_val("gnt_id", 32'(gnt_id), (m_gid >= 0) ? 32'(m_gid) : 32'd0);
        check_val("gnt_valid", 32'(gnt_valid), 32'(m_gid >= 0));
        check_val("timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    task automatic step(input logic [N-1:0] r, input logic a);
        req     = r;
        gnt_ack = a;
        @(posedge clk);
        model_update(r, a);
        #1;
        req     = '0;
        gnt_ack = 1'b0;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    // Acks each grant once it has waited ack_delay cycles; bounded to 60 cycles.
    task automatic serve(input int ack_delay, output int ids[$]);
        logic prev_v;
        prev_v = gnt_valid;
        ids    = {};
        for (int c = 0; c < 60; c++) begin
            step('0, (m_gid >= 0) && (m_age >= ack_delay));
            if (gnt_valid && !prev_v) ids.push_back(int'(gnt_id));
            prev_v = gnt_valid;
            if (m_gid < 0 && m_gap == 0 && m_pend == '0) break;
        end
    endtask

    initial begin
        int ids[$];
        int v_cnt;
        int e_cnt;
        req     = '0;
        gnt_ack = 1'b0;
        rst_n   = 1'b1;
        #1;
        do_reset();
        repeat (10) step('0, 1'b0);

        // Single request, ack two cycles after grant.
        step(4'b0010, 1'b0);
        check_val("single_pend_latency", 32'(pending), 32'h2);
        step('0, 1'b0);
        check_val("single_gnt_id", 32'(gnt_id), 32'd1);
        serve(2, ids);

        // Simultaneous requests granted 3, 1, 0.
        step(4'b1011, 1'b0);
        serve(0, ids);
        check_val("order_len", 32'(ids.size()), 32'd3);
        if (ids.size() == 3) begin
            check_val("order_0", 32'(ids[0]), 32'd3);
            check_val("order_1", 32'(ids[1]), 32'd1);
            check_val("order_2", 32'(ids[2]), 32'd0);
        end

        // No preemption by a higher request during a grant.
        step(4'b0001, 1'b0);
        step('0, 1'b0);
        step(4'b1000, 1'b0);
        step('0, 1'b0);
        check_val("nopreempt_gnt", 32'(gnt), 32'h1);
        serve(0, ids);
        check_val("nopreempt_next", (ids.size() > 0) ? 32'(ids[0]) : 32'hFFFF, 32'd3);

        // Timeout without ack.
        step(4'b0100, 1'b0);
        v_cnt = 0;
        e_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step('0, 1'b0);
            v_cnt += int'(gnt_valid);
            e_cnt += int'(timeout_err);
        end
        check_val("timeout_valid_cycles", 32'(v_cnt), 32'(T));
        check_val("timeout_err_pulses", 32'(e_cnt), 32'd1);
        check_val("timeout_pend_clear", 32'(pending), 32'h0);

        // Ack on the last allowed cycle wins over the timeout.
        step(4'b0100, 1'b0);
        e_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step('0, (m_gid >= 0) && (m_age == T - 1));
            e_cnt += int'(timeout_err);
        end
        check_val("ack_beats_timeout", 32'(e_cnt), 32'd0);

        // Set wins over clear on the ack cycle.
        step(4'b0010, 1'b0);
        step('0, 1'b0);
        step(4'b0010, 1'b1);
        check_val("setwins_pend", 32'(pending[1]), 32'd1);
        serve(1, ids);
        check_val("setwins_regrant", (ids.size() > 0) ? 32'(ids[0]) : 32'hFFFF, 32'd1);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] r;
            r = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            step(r, $urandom_range(0, 2) == 0);
        end

        // Asynchronous reset while a grant is active.
        step(4'b0001, 1'b0);
        step('0, 1'b0);
        check_val("pre_reset_valid", 32'(gnt_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step('0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
